// File: rtl/pitch_shift_sched.sv
// pitch_shift_sched - sample-rate sequencer for a delay-line pitch shifter.
//
// Once per sample_clk period the FSM shares one external single-port delay
// RAM between the sample write and two read heads spaced half a window apart.
// The read-head delay accumulator d moves by the latched pitch CV each sample.
// The two heads are crossfaded with triangular gains, so the head that is
// about to jump is always silent when it jumps.
//
// Ports
//   clk         system clock
//   rst_n       synchronous reset, active low
//   sample_clk  sample-rate strobe source, asynchronous to clk
//   sample_in   signed audio sample (W)
//   pitch       signed pitch CV (W)
//   ram_addr    delay RAM address (ADDR_W)
//   ram_we      delay RAM write enable
//   ram_wdata   delay RAM write data (W)
//   ram_rdata   delay RAM read data, valid 1 clk after address (W)
//   sample_out  signed transposed sample, held between updates (W)
//   busy        high while the FSM is not idle
//   overrun     sticky: a strobe arrived while busy
//
// state | meaning
// IDLE  | waiting for a sample strobe
// WRITE | write latched sample at wr_ptr
// RD_A  | address head A (wr_ptr - p)
// RD_B  | address head B (A - N/2), capture head A data
// CAP_B | capture head B data
// MIX   | crossfade into sample_out, advance wr_ptr and d
module pitch_shift_sched #(
  parameter int W      = 16,
  parameter int ADDR_W = 10,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_clk,
  input  logic [W-1:0]      sample_in,
  input  logic [W-1:0]      pitch,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [W-1:0]      ram_wdata,
  input  logic [W-1:0]      ram_rdata,
  output logic [W-1:0]      sample_out,
  output logic              busy,
  output logic              overrun
);

  localparam int DW = ADDR_W + FRAC_W;
  localparam int PW = W + ADDR_W + 1;
  localparam int SW = PW + 1;
  localparam int SH = W - 1 - FRAC_W;
  localparam logic [ADDR_W-1:0] HALF = {1'b1, {(ADDR_W-1){1'b0}}};
  localparam logic [DW-1:0] D_INIT = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    RD_A  = 3'd2,
    RD_B  = 3'd3,
    CAP_B = 3'd4,
    MIX   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic              sync1, sync2, sync3;
  logic              strobe;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DW-1:0]     d;
  logic [W-1:0]      smp_lat;
  logic [W-1:0]      pitch_lat;
  logic [W-1:0]      a, b;

  logic [ADDR_W-1:0]  p;
  logic [ADDR_W-1:0]  addr_a, addr_b;
  logic [ADDR_W-1:0]  gain_a, gain_b;
  logic signed [W-1:0]  pitch_sh;
  logic [DW-1:0]        delta;
  logic signed [PW-1:0] prod_a, prod_b;
  logic signed [SW-1:0] mix_sum;

  assign strobe = sync2 & ~sync3;

  assign p      = d[DW-1:FRAC_W];
  assign addr_a = wr_ptr - p;
  assign addr_b = addr_a - HALF;

  // Triangle gain: zero at p=0 (head A jump point), peak at p=N/2.
  assign gain_a = p[ADDR_W-1] ? {~p[ADDR_W-2:0], 1'b0} : {p[ADDR_W-2:0], 1'b0};
  assign gain_b = {ADDR_W{1'b1}} - gain_a;

  assign pitch_sh = $signed(pitch_lat) >>> SH;
  assign delta    = DW'(pitch_sh);

  // Gains are unsigned, so they get a zero MSB before the signed multiply.
  assign prod_a  = PW'($signed(a)) * PW'($signed({1'b0, gain_a}));
  assign prod_b  = PW'($signed(b)) * PW'($signed({1'b0, gain_b}));
  assign mix_sum = SW'(prod_a) + SW'(prod_b);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (strobe) state_nxt = WRITE;
      WRITE: begin
        ram_addr  = wr_ptr;
        // Gated by rst_n so a reset landing on WRITE never corrupts the RAM.
        ram_we    = rst_n;
        ram_wdata = smp_lat;
        state_nxt = RD_A;
      end
      RD_A: begin
        ram_addr  = addr_a;
        state_nxt = RD_B;
      end
      RD_B: begin
        ram_addr  = addr_b;
        state_nxt = CAP_B;
      end
      CAP_B:   state_nxt = MIX;
      MIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      wr_ptr     <= '0;
      d          <= D_INIT;
      smp_lat    <= '0;
      pitch_lat  <= '0;
      a          <= '0;
      b          <= '0;
      sample_out <= '0;
      overrun    <= 1'b0;
    end else begin
      sync1 <= sample_clk;
      sync2 <= sync1;
      sync3 <= sync2;
      if (strobe) begin
        if (state == IDLE) begin
          smp_lat   <= sample_in;
          pitch_lat <= pitch;
        end else begin
          overrun <= 1'b1;
        end
      end
      case (state)
        RD_B:  a <= ram_rdata;
        CAP_B: b <= ram_rdata;
        MIX: begin
          sample_out <= W'(mix_sum >>> ADDR_W);
          wr_ptr     <= wr_ptr + 1'b1;
          d          <= d - delta;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_shift_sched.sv
module tb_pitch_shift_sched;
  localparam int W = 16;
  localparam int AW = 10;
  localparam int N = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_clk = 1'b0;
  logic [W-1:0]  sample_in = '0;
  logic [W-1:0]  pitch = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_rdata;
  logic [W-1:0]  sample_out;
  logic          busy;
  logic          overrun;

  pitch_shift_sched #(.W(W), .ADDR_W(AW), .FRAC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk),
    .sample_in(sample_in), .pitch(pitch),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .sample_out(sample_out),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // External synchronous single-port RAM.
  logic [W-1:0] ram [N];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_asrt++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    n_asrt++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Behavioural model: delay line as an integer array, pointers as integers.
  int mdl_mem [N];
  int m_wr, m_d;
  int prev_out, cur_out;
  int exp_wr, exp_x, exp_a, exp_b, exp_ovr;
  int m_p;
  int since = -1;
  bit chk_en = 1'b0;

  function automatic int gain_of(input int p);
    if (p >= N / 2) return ((N - 1 - p) * 2) % N;
    return (p * 2) % N;
  endfunction

  function automatic int delta_of(input int pit);
    return pit >>> 7;
  endfunction

  task automatic model_reset();
    m_wr = 0;
    m_d = (N / 2) * 256;
    prev_out = 0;
    cur_out = 0;
    exp_ovr = 0;
  endtask

  task automatic model_step(input int x, input int pit);
    int ga, gb;
    exp_wr = m_wr;
    exp_x = x;
    mdl_mem[m_wr] = x;
    m_p = (m_d / 256) % N;
    exp_a = (m_wr - m_p + 2 * N) % N;
    exp_b = (exp_a + N / 2) % N;
    ga = gain_of(m_p);
    gb = (N - 1) - ga;
    prev_out = cur_out;
    cur_out = (mdl_mem[exp_a] * ga + mdl_mem[exp_b] * gb) >>> AW;
    m_wr = (m_wr + 1) % N;
    m_d = (m_d - delta_of(pit)) & 262143;
  endtask

  // One sample period; ovr adds a second sample_clk edge 4 clks later.
  task automatic do_sample(input int x, input int pit, input bit ovr);
    @(posedge clk); #1;
    model_step(x, pit);
    sample_in = x[W-1:0];
    pitch = pit[W-1:0];
    sample_clk = 1'b1;
    since = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      since = k;
      if (ovr) begin
        if (k == 2) sample_clk = 1'b0;
        if (k == 4) sample_clk = 1'b1;
        if (k == 7) exp_ovr = 1;
        if (k == 8) sample_clk = 1'b0;
      end else if (k == 4) begin
        sample_clk = 1'b0;
      end
    end
    since = -1;
  endtask

  function automatic int rnd_smp();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("overrun", int'(overrun), exp_ovr);
      chk("busy", int'(busy), (since >= 3 && since <= 7) ? 1 : 0);
      if (since == 3) begin
        chk("we_write", int'(ram_we), 1);
        chk("addr_write", int'(ram_addr), exp_wr);
        chk("wdata", int'($signed(ram_wdata)), exp_x);
      end else begin
        chk("we_idle", int'(ram_we), 0);
      end
      if (since == 4) chk("addr_rd_a", int'(ram_addr), exp_a);
      if (since == 5) chk("addr_rd_b", int'(ram_addr), exp_b);
      if (since >= 0 && since < 8) chk("out_hold", int'($signed(sample_out)), prev_out);
      else                          chk("out_new", int'($signed(sample_out)), cur_out);
    end
  end

  initial begin
    int x;
    for (int i = 0; i < N; i++) begin
      ram[i] = '0;
      mdl_mem[i] = 0;
    end
    model_reset();

    // Model pins.
    chk("pin_gain_p0", gain_of(0), 0);
    chk("pin_gain_p1", gain_of(1), 2);
    chk("pin_gain_p512", gain_of(512), 1022);
    chk("pin_gain_p1023", gain_of(1023), 0);
    chk("pin_delta_up", delta_of(4096), 32);
    chk("pin_delta_dn", delta_of(-32768), -256);

    // Reset: 4 clocks low.
    repeat (4) @(negedge clk);
    chk("rst_out", int'(sample_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_wdata", int'(ram_wdata), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Unity: fixed delay, constant input.
    for (int i = 0; i < 1100; i++) do_sample(1000, 0, 1'b0);
    chk("unity_out", int'($signed(sample_out)), 999);

    // Impulse delayed by N/2 samples.
    do_sample(16000, 0, 1'b0);
    for (int i = 0; i < 512; i++) do_sample(0, 0, 1'b0);
    chk_tol("impulse_out", int'($signed(sample_out)), 15968, 1);
    do_sample(0, 0, 1'b0);

    // Shift up through the p=0 wrap, random audio.
    for (int i = 0; i < 4110; i++) do_sample(rnd_smp(), 4096, 1'b0);

    // Shift down: p increments each sample, wraps N-1 -> 0.
    for (int i = 0; i < 100; i++) do_sample(rnd_smp(), -32768, 1'b0);

    // Random pitch and audio.
    for (int i = 0; i < 200; i++) do_sample(rnd_smp(), rnd_smp(), 1'b0);

    // Overrun: second strobe 4 clks after the first.
    do_sample(rnd_smp(), 0, 1'b1);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 3; i++) do_sample(rnd_smp(), 0, 1'b0);
    chk("ovr_sticky", int'(overrun), 1);

    // Reset while in RD_B: the write already happened, the sample is lost.
    chk_en = 1'b0;
    x = rnd_smp();
    @(posedge clk); #1;
    sample_in = x[W-1:0];
    sample_clk = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
    end
    chk("rd_b_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    sample_clk = 1'b0;
    @(negedge clk);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_we", int'(ram_we), 0);
    chk("mrst_out", int'(sample_out), 0);
    chk("mrst_ovr", int'(overrun), 0);
    chk("mrst_addr", int'(ram_addr), 0);
    mdl_mem[m_wr] = x;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) do_sample(rnd_smp(), rnd_smp(), 1'b0);

    // Reset landing on WRITE: no RAM write in the reset cycle.
    chk_en = 1'b0;
    x = rnd_smp();
    @(posedge clk); #1;
    sample_in = x[W-1:0];
    sample_clk = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("wrst_we", int'(ram_we), 0);
    @(posedge clk); #1;
    sample_clk = 1'b0;
    @(negedge clk);
    chk("wrst_busy", int'(busy), 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 20; i++) do_sample(rnd_smp(), rnd_smp(), 1'b0);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
